// File: rtl/instr_encoder_loader.sv
// Packs instruction field bundles into 32-bit words and streams them into imem.
// Optional OPCODE_CHECK_EN: drop illegal opcodes and report them on err/err_count.
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
`ifdef OPCODE_CHECK_EN
    ,
    parameter int NUM_OPCODES = 20
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [4:0]        in_dest,
    input  logic [4:0]        in_src1,
    input  logic [4:0]        in_src2,
    input  logic [15:0]       in_imm,
    input  logic              in_imm_flag,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count
`ifdef OPCODE_CHECK_EN
    ,
    output logic              err,
    output logic [7:0]        err_count
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;
    logic                fin_q, fin_d;
    logic                accept;
    logic                legal;
    logic                at_max;
    logic [31:0]         enc;
`ifdef OPCODE_CHECK_EN
    logic                err_q, err_d;
    logic [7:0]          errc_q, errc_d;
`endif

    assign in_ready = (state_q == LOAD) && !start && !fin_q
                      && (!we_q || imem_ready);
    assign accept   = in_valid && in_ready;
    assign at_max   = (addr_q == {ADDR_W{1'b1}});
    assign enc      = {in_opcode, in_dest, in_src1, in_imm_flag,
                       in_imm_flag ? in_imm : {in_src2, 11'b0}};

`ifdef OPCODE_CHECK_EN
    assign legal = ({27'b0, in_opcode} < 32'(NUM_OPCODES));
`else
    assign legal = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q && !imem_ready;
        addr_d  = addr_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        fin_d   = fin_q;
`ifdef OPCODE_CHECK_EN
        err_d   = 1'b0;
        errc_d  = errc_q;
`endif
        if (state_q == LOAD && fin_q && we_q && imem_ready) begin
            state_d = DONE;
            done_d  = 1'b1;
            fin_d   = 1'b0;
        end
        if (accept) begin
            if (legal) begin
                we_d    = 1'b1;
                waddr_d = addr_q;
                wdata_d = enc;
                cnt_d   = cnt_q + 1'b1;
                if (!at_max) addr_d = addr_q + 1'b1;
                if (in_last || at_max) fin_d = 1'b1;
                if (at_max && !in_last) ovf_d = 1'b1;
            end else begin
`ifdef OPCODE_CHECK_EN
                err_d = 1'b1;
                if (errc_q != 8'hFF) errc_d = errc_q + 8'd1;
`endif
                // an illegal last bundle still ends the load once the bus drains
                if (in_last) begin
                    if (we_d) begin
                        fin_d = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
        end
        if (start) begin
            state_d = LOAD;
            we_d    = 1'b0;
            addr_d  = BASE;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            done_d  = 1'b0;
            fin_d   = 1'b0;
`ifdef OPCODE_CHECK_EN
            err_d   = 1'b0;
            errc_d  = 8'd0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= BASE;
            waddr_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            fin_q   <= 1'b0;
`ifdef OPCODE_CHECK_EN
            err_q   <= 1'b0;
            errc_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            fin_q   <= fin_d;
`ifdef OPCODE_CHECK_EN
            err_q   <= err_d;
            errc_q  <= errc_d;
`endif
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = waddr_q;
    assign imem_wdata = wdata_q;
    assign busy       = (state_q == LOAD);
    assign done       = done_q;
    assign overflow   = ovf_q;
    assign word_count = cnt_q;
`ifdef OPCODE_CHECK_EN
    assign err        = err_q;
    assign err_count  = errc_q;
`endif

endmodule
